// File: rtl/commit_monitor_pkg.sv
// Shared types for the retirement-stream monitor.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
// Contents: the 3-bit monitor state encoding and a helper that tells
// whether a state still records trace entries.
package commit_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_HALTED  = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_ERROR   = 3'd4
  } mon_state_t;

  // Only the two live states push retired PCs into the trace buffer.
  function automatic logic is_tracing(input mon_state_t s);
    return (s == ST_IDLE) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous trace FIFO holding retired PCs for the host.
// Latency: a push is visible at the head one cycle later (no fall-through).
// Backpressure: a push into a full FIFO is dropped unless a pop happens in the same cycle.
// Ports: clk, rst (async active-low), clear (sync), push/din, pop,
//        dout (head), valid (not empty), full.
module trace_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // When full, a simultaneous pop frees the slot the push is about to use.
  assign do_push = push && (!full || do_pop);

  assign valid = !empty;
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/commit_monitor.sv
// Checks PC linkage of the retirement stream, detects halt and watchdog timeout, traces PCs.
// Latency: all outputs registered; effects of a commit are visible the cycle after it is sampled.
// Backpressure: trace port is valid/ready; a full trace buffer drops new PCs and sets overflow.
// Ports: clk, rst (async active-low), commit/commit_pc/commit_pre_pc (retire stream),
//        clear (sync soft clear), trace_valid/trace_ready/trace_pc (host drain),
//        commit_cnt, state, halted, timeout, seq_err, overflow, err_pc (status).
module commit_monitor
  import commit_monitor_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 8,
  parameter int WDOG_CYCLES = 1024,
  parameter int HALT_REPEAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            commit,
  input  logic [XLEN-1:0] commit_pc,
  input  logic [XLEN-1:0] commit_pre_pc,
  input  logic            clear,
  output logic            trace_valid,
  input  logic            trace_ready,
  output logic [XLEN-1:0] trace_pc,
  output logic [31:0]     commit_cnt,
  output logic [2:0]      state,
  output logic            halted,
  output logic            timeout,
  output logic            seq_err,
  output logic            overflow,
  output logic [XLEN-1:0] err_pc
);

  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam int RW = $clog2(HALT_REPEAT + 1);

  mon_state_t      st;
  logic [XLEN-1:0] last_pc;
  logic [WW-1:0]   wdog;
  logic [RW-1:0]   rep;
  logic            push;
  logic            pop;
  logic            fifo_full;

  assign state = st;
  assign push  = commit && !clear && is_tracing(st);
  assign pop   = trace_valid && trace_ready;

  trace_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_trace_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .din   (commit_pc),
    .pop   (trace_ready),
    .dout  (trace_pc),
    .valid (trace_valid),
    .full  (fifo_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st         <= ST_IDLE;
      last_pc    <= '0;
      wdog       <= '0;
      rep        <= '0;
      commit_cnt <= '0;
      halted     <= 1'b0;
      timeout    <= 1'b0;
      seq_err    <= 1'b0;
      overflow   <= 1'b0;
      err_pc     <= '0;
    end else if (clear) begin
      st         <= ST_IDLE;
      last_pc    <= '0;
      wdog       <= '0;
      rep        <= '0;
      commit_cnt <= '0;
      halted     <= 1'b0;
      timeout    <= 1'b0;
      seq_err    <= 1'b0;
      overflow   <= 1'b0;
      err_pc     <= '0;
    end else begin
      // Counting and PC history continue even in the terminal states.
      if (commit) begin
        commit_cnt <= commit_cnt + 32'd1;
        last_pc    <= commit_pc;
      end
      if (push && fifo_full && !pop) overflow <= 1'b1;

      case (st)
        ST_IDLE: begin
          // First retirement has no predecessor to check against.
          if (commit) begin
            st   <= ST_RUN;
            wdog <= '0;
            rep  <= '0;
          end
        end
        ST_RUN: begin
          if (commit) begin
            wdog <= '0;
            if (commit_pre_pc != last_pc) begin
              st      <= ST_ERROR;
              seq_err <= 1'b1;
              err_pc  <= commit_pc;
            end else if (commit_pc == commit_pre_pc) begin
              if (rep == RW'(HALT_REPEAT - 1)) begin
                st     <= ST_HALTED;
                halted <= 1'b1;
              end
              rep <= rep + 1'b1;
            end else begin
              rep <= '0;
            end
          end else if (wdog == WW'(WDOG_CYCLES)) begin
            // Fires on the cycle after the count reaches the limit, i.e.
            // WDOG_CYCLES+1 commit-free cycles after the last retirement.
            st      <= ST_TIMEOUT;
            timeout <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_monitor.sv
// Bench for commit_monitor: directed retirement streams, a queue-based
// reference model updated every clock, and a per-cycle comparison of all
// outputs against it, plus literal expectations at key points.
module tb_commit_monitor;

  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int WD    = 16;
  localparam int HR    = 4;

  localparam int S_IDLE    = 0;
  localparam int S_RUN     = 1;
  localparam int S_HALTED  = 2;
  localparam int S_TIMEOUT = 3;
  localparam int S_ERROR   = 4;

  logic            clk;
  logic            rst;
  logic            commit;
  logic [XLEN-1:0] commit_pc;
  logic [XLEN-1:0] commit_pre_pc;
  logic            clear;
  logic            trace_valid;
  logic            trace_ready;
  logic [XLEN-1:0] trace_pc;
  logic [31:0]     commit_cnt;
  logic [2:0]      state;
  logic            halted;
  logic            timeout;
  logic            seq_err;
  logic            overflow;
  logic [XLEN-1:0] err_pc;

  commit_monitor #(
    .XLEN        (XLEN),
    .DEPTH       (DEPTH),
    .WDOG_CYCLES (WD),
    .HALT_REPEAT (HR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .commit        (commit),
    .commit_pc     (commit_pc),
    .commit_pre_pc (commit_pre_pc),
    .clear         (clear),
    .trace_valid   (trace_valid),
    .trace_ready   (trace_ready),
    .trace_pc      (trace_pc),
    .commit_cnt    (commit_cnt),
    .state         (state),
    .halted        (halted),
    .timeout       (timeout),
    .seq_err       (seq_err),
    .overflow      (overflow),
    .err_pc        (err_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: retired-PC queue, count of commit-free cycles and
  // length of the current self-loop run.
  int          m_state;
  logic [31:0] m_cnt;
  logic [31:0] m_last;
  logic [31:0] m_err;
  int          m_idle;
  int          m_run;
  bit          m_halt, m_to, m_seq, m_ovf;
  logic [31:0] m_q[$];
  int          m_n;
  bit          m_pop, m_push;

  task automatic model_reset();
    m_state = S_IDLE; m_cnt = 0; m_last = 0; m_err = 0;
    m_idle = 0; m_run = 0;
    m_halt = 0; m_to = 0; m_seq = 0; m_ovf = 0;
    m_q.delete();
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst || clear) begin
        model_reset();
      end else begin
        m_n    = m_q.size();
        m_pop  = (m_n > 0) && trace_ready;
        m_push = commit && (m_state == S_IDLE || m_state == S_RUN);
        if (m_pop) m_q.delete(0);
        if (m_push) begin
          if (m_n == DEPTH && !m_pop) m_ovf = 1;
          else m_q.push_back(commit_pc);
        end
        if (m_state == S_IDLE) begin
          if (commit) begin
            m_state = S_RUN; m_idle = 0; m_run = 0;
          end
        end else if (m_state == S_RUN) begin
          if (commit) begin
            m_idle = 0;
            if (commit_pre_pc !== m_last) begin
              m_state = S_ERROR; m_seq = 1; m_err = commit_pc;
            end else if (commit_pc == commit_pre_pc) begin
              m_run++;
              if (m_run >= HR) begin
                m_state = S_HALTED; m_halt = 1;
              end
            end else begin
              m_run = 0;
            end
          end else begin
            m_idle++;
            if (m_idle > WD) begin
              m_state = S_TIMEOUT; m_to = 1;
            end
          end
        end
        if (commit) begin
          m_cnt  = m_cnt + 1;
          m_last = commit_pc;
        end
      end
    end
  end

  // Per-cycle comparison, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("state", state, m_state);
        chk("commit_cnt", commit_cnt, m_cnt);
        chk("halted", halted, m_halt);
        chk("timeout", timeout, m_to);
        chk("seq_err", seq_err, m_seq);
        chk("overflow", overflow, m_ovf);
        chk("err_pc", err_pc, m_err);
        chk("trace_valid", trace_valid, m_q.size() > 0);
        if (m_q.size() > 0) chk("trace_pc", trace_pc, m_q[0]);
      end
    end
  end

  task automatic step(input logic c, input logic [31:0] pc, input logic [31:0] pre,
                      input logic rdy, input logic clr);
    commit        = c;
    commit_pc     = pc;
    commit_pre_pc = pre;
    trace_ready   = rdy;
    clear         = clr;
    @(negedge clk);
  endtask

  logic [31:0] seq_exp [3];

  initial begin
    rst = 1'b0; commit = 1'b0; commit_pc = '0; commit_pre_pc = '0;
    clear = 1'b0; trace_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_cnt", commit_cnt, 0);
    chk("rst_valid", trace_valid, 0);
    chk("rst_trace_pc", trace_pc, 0);
    chk("rst_err_pc", err_pc, 0);
    rst = 1'b1;
    step(0, 0, 0, 0, 0);

    // Sequential stream
    step(1, 32'h8000_0000, 32'h0000_dead, 0, 0);
    step(1, 32'h8000_0004, 32'h8000_0000, 0, 0);
    step(1, 32'h8000_0008, 32'h8000_0004, 0, 0);
    chk("seq_state", state, S_RUN);
    chk("seq_cnt", commit_cnt, 3);
    chk("seq_flags", {halted, timeout, seq_err, overflow}, 0);
    seq_exp[0] = 32'h8000_0000; seq_exp[1] = 32'h8000_0004; seq_exp[2] = 32'h8000_0008;
    for (int i = 0; i < 3; i++) begin
      chk("seq_pop_valid", trace_valid, 1);
      chk("seq_pop_pc", trace_pc, seq_exp[i]);
      step(0, 0, 0, 1, 0);
    end
    chk("seq_drained", trace_valid, 0);

    // Sequence error, then commits still counted
    step(1, 32'h8000_0010, 32'h8000_0000, 0, 0);
    chk("err_state", state, S_ERROR);
    chk("err_flag", seq_err, 1);
    chk("err_pc_val", err_pc, 32'h8000_0010);
    step(1, 32'h8000_0014, 32'h8000_0010, 0, 0);
    chk("err_cnt", commit_cnt, 5);
    chk("err_sticky", state, S_ERROR);

    // Clear with a coinciding commit
    step(1, 32'h8000_0018, 32'h8000_0014, 0, 1);
    chk("clr_state", state, S_IDLE);
    chk("clr_cnt", commit_cnt, 0);
    chk("clr_valid", trace_valid, 0);
    chk("clr_seq_err", seq_err, 0);
    chk("clr_err_pc", err_pc, 0);
    step(0, 0, 0, 0, 0);

    // Halt: three loops, a break, three loops (no halt), then the fourth
    step(1, 32'h8000_001c, 32'h0, 1, 0);
    step(1, 32'h8000_0020, 32'h8000_001c, 1, 0);
    repeat (3) step(1, 32'h8000_0020, 32'h8000_0020, 1, 0);
    step(1, 32'h8000_0024, 32'h8000_0020, 1, 0);
    repeat (3) step(1, 32'h8000_0024, 32'h8000_0024, 1, 0);
    chk("halt_not_yet", halted, 0);
    chk("halt_run", state, S_RUN);
    step(1, 32'h8000_0024, 32'h8000_0024, 1, 0);
    chk("halt_set", halted, 1);
    chk("halt_state", state, S_HALTED);
    step(0, 0, 0, 1, 1);

    // Watchdog: a commit after 14 idle cycles rearms it, then 17 idle cycles fire it
    step(1, 32'h8000_0040, 32'h0, 1, 0);
    repeat (14) step(0, 0, 0, 1, 0);
    step(1, 32'h8000_0044, 32'h8000_0040, 1, 0);
    repeat (16) step(0, 0, 0, 1, 0);
    chk("wdog_16", timeout, 0);
    chk("wdog_16_state", state, S_RUN);
    step(0, 0, 0, 1, 0);
    chk("wdog_17", timeout, 1);
    chk("wdog_state", state, S_TIMEOUT);
    step(0, 0, 0, 0, 1);

    // Overflow: fill 8, push+pop when full, then a dropped push
    for (int i = 0; i < 8; i++)
      step(1, 32'h100 + 32'(4 * i), 32'h100 + 32'(4 * i) - 32'd4, 0, 0);
    chk("full_valid", trace_valid, 1);
    chk("full_no_ovf", overflow, 0);
    step(1, 32'h120, 32'h11c, 1, 0);
    chk("pushpop_no_ovf", overflow, 0);
    step(1, 32'h124, 32'h120, 0, 0);
    chk("ovf_set", overflow, 1);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_pc", trace_pc, 32'h100 + 32'(4 * i));
      step(0, 0, 0, 1, 0);
    end
    chk("drain_empty", trace_valid, 0);
    step(0, 0, 0, 0, 1);

    // Asynchronous reset mid-burst
    step(1, 32'h200, 32'h0, 0, 0);
    step(1, 32'h204, 32'h200, 0, 0);
    commit = 1'b1; commit_pc = 32'h208; commit_pre_pc = 32'h204;
    #3 rst = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_cnt", commit_cnt, 0);
    chk("arst_valid", trace_valid, 0);
    chk("arst_trace_pc", trace_pc, 0);
    chk("arst_flags", {halted, timeout, seq_err, overflow}, 0);
    chk("arst_err_pc", err_pc, 0);
    commit = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    chk("post_rst_state", state, S_IDLE);
    chk("post_rst_cnt", commit_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
